avalon_pio_gpio: RTL and testbench

Parametrised Avalon-MM GPIO slave, successor to the fixed-width output-only PIO ports used for OTG/HPI control. Provides per-bit direction, atomic set/clear writes, synchronised input sampling, edge capture and a maskable level interrupt. Sits on the Nios II data bus alongside the other lab7_soc PIO slaves.

---
 rtl/avalon_pio_gpio_pkg.sv | 24 ++
 rtl/avalon_pio_gpio_if.sv | 11 +
 rtl/avalon_pio_gpio_edge_detect.sv | 80 ++++++++
 rtl/avalon_pio_gpio.sv | 99 +++++++++
 tb/tb_avalon_pio_gpio.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/avalon_pio_gpio_pkg.sv
// Shared constants for the Avalon-MM GPIO slave: register map, edge types, arm depth.
// The arm depth follows the input stage selected by PIO_INPUT_SYNC_EN.
package avalon_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE    = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

`ifdef PIO_INPUT_SYNC_EN
   localparam logic [1:0] ARM_DEPTH = 2'd3;
`else
   localparam logic [1:0] ARM_DEPTH = 2'd2;
`endif

endpackage

// File: rtl/avalon_pio_gpio_if.sv
// Avalon-MM slave bus bundle for the GPIO block (read latency 0).
interface avalon_pio_gpio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_gpio_edge_detect.sv
// Input sampling, previous-sample register, arming counter and gated edge-detect vector.
// With PIO_INPUT_SYNC_EN defined the pins pass through a 2-flop synchroniser.
module pio_edge_detect
   import avalon_pio_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter edge_type_e  EDGE_TYPE = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   input  logic [WIDTH-1:0] dir,
   output logic [WIDTH-1:0] sampled_in,
   output logic [WIDTH-1:0] det
);

   logic [WIDTH-1:0] sampled_r;
   logic [WIDTH-1:0] prev_r;
   logic [1:0]       arm_cnt_r;
   logic             armed_s;
   logic [WIDTH-1:0] raw_s;

`ifdef PIO_INPUT_SYNC_EN
   logic [WIDTH-1:0] sync1_r;

   // Two-flop synchroniser for asynchronous pin inputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_r   <= '0;
         sampled_r <= '0;
      end else begin
         sync1_r   <= in_port;
         sampled_r <= sync1_r;
      end
   end
`else
   // Single sampling register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sampled_r <= '0;
      end else begin
         sampled_r <= in_port;
      end
   end
`endif

   // Previous sample and arming counter; arming hides the first fill of the pipeline
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_r    <= '0;
         arm_cnt_r <= 2'd0;
      end else begin
         prev_r <= sampled_r;
         if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
         end
      end
   end

   assign armed_s    = (arm_cnt_r == ARM_DEPTH);
   assign sampled_in = sampled_r;

   // Edge selection, gated to armed input-direction bits
   always_comb begin
      raw_s = '0;
      det   = '0;
      case (EDGE_TYPE)
         EDGE_RISE: raw_s = sampled_r & ~prev_r;
         EDGE_FALL: raw_s = ~sampled_r & prev_r;
         EDGE_ANY:  raw_s = sampled_r ^ prev_r;
         default:   raw_s = '0;
      endcase
      if (armed_s) begin
         det = raw_s & ~dir;
      end else begin
         det = '0;
      end
   end

endmodule

// File: rtl/avalon_pio_gpio.sv
// Parametrised Avalon-MM GPIO slave: direction, set/clear writes, edge capture, maskable irq.
// Build option PIO_INPUT_SYNC_EN adds a 2-flop input synchroniser (see pio_edge_detect).
module avalon_pio_gpio
   import avalon_pio_pkg::*;
#(
   parameter int unsigned     WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0,
   parameter int unsigned     EDGE_TYPE   = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   avalon_pio_gpio_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic [WIDTH-1:0]   out_port,
   output logic [WIDTH-1:0]   oe_port,
   output logic               irq
);

   logic [WIDTH-1:0] data_out_r;
   logic [WIDTH-1:0] dir_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic [WIDTH-1:0] edge_cap_r;
   logic [WIDTH-1:0] sampled_s;
   logic [WIDTH-1:0] det_s;
   logic [WIDTH-1:0] w1c_s;
   logic [WIDTH-1:0] wd_s;
   logic [WIDTH-1:0] rd_s;
   logic             wr_s;
   logic             unused_s;

   localparam logic [1:0] EDGE_SEL = EDGE_TYPE[1:0];

   pio_edge_detect #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (edge_type_e'(EDGE_SEL))
   ) u_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .dir        (dir_r),
      .sampled_in (sampled_s),
      .det        (det_s)
   );

   assign wr_s     = bus.chipselect && !bus.write_n;
   assign wd_s     = bus.writedata[WIDTH-1:0];
   assign unused_s = ^bus.writedata;

   // EDGE writes clear captured bits written as 1
   always_comb begin
      w1c_s = '0;
      if (wr_s && (bus.address == ADDR_EDGE)) begin
         w1c_s = wd_s;
      end else begin
         w1c_s = '0;
      end
   end

   // Register file updates; a same-cycle detection beats a W1C
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out_r <= RESET_VALUE;
         dir_r      <= DIR_RESET;
         irq_mask_r <= '0;
         edge_cap_r <= '0;
      end else begin
         if (wr_s) begin
            case (bus.address)
               ADDR_DATA:    data_out_r <= wd_s;
               ADDR_DIR:     dir_r      <= wd_s;
               ADDR_IRQMASK: irq_mask_r <= wd_s;
               ADDR_OUTSET:  data_out_r <= data_out_r | wd_s;
               ADDR_OUTCLR:  data_out_r <= data_out_r & ~wd_s;
               default:      ;
            endcase
         end
         edge_cap_r <= (edge_cap_r & ~w1c_s) | det_s;
      end
   end

   // Zero-latency read mux; OUTSET/OUTCLR and unused addresses read 0
   always_comb begin
      rd_s = '0;
      case (bus.address)
         ADDR_DATA:    rd_s = (dir_r & data_out_r) | (~dir_r & sampled_s);
         ADDR_DIR:     rd_s = dir_r;
         ADDR_IRQMASK: rd_s = irq_mask_r;
         ADDR_EDGE:    rd_s = edge_cap_r;
         default:      rd_s = '0;
      endcase
   end

   assign bus.readdata = 32'(rd_s);
   assign out_port     = data_out_r;
   assign oe_port      = dir_r;
   assign irq          = |(edge_cap_r & irq_mask_r);

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Directed self-checking bench for avalon_pio_gpio (WIDTH=8, RESET_VALUE=A5, DIR_RESET=0F).
// Latency expectations follow PIO_INPUT_SYNC_EN.
module tb_avalon_pio_gpio;
   import avalon_pio_pkg::*;

`ifdef PIO_INPUT_SYNC_EN
   localparam int SAMP_LAT = 2;
`else
   localparam int SAMP_LAT = 1;
`endif
   localparam int IRQ_LAT = SAMP_LAT + 1;

   logic       clk;
   logic       reset_n;
   logic [7:0] in_port;
   logic [7:0] out_port;
   logic [7:0] oe_port;
   logic       irq;
   logic [31:0] rd_val;
   int         n_checks;
   int         n_pass;

   avalon_pio_gpio_if bus ();

   avalon_pio_gpio #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5),
      .DIR_RESET   (8'h0F),
      .EDGE_TYPE   (0)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .in_port  (in_port),
      .out_port (out_port),
      .oe_port  (oe_port),
      .irq      (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'h0;
      in_port        = 8'h50;
      reset_n        = 1'b0;

      // reset state
      repeat (3) tick();
      check("rst_out_port", {24'h0, out_port}, 32'h0000_00A5);
      check("rst_oe_port", {24'h0, oe_port}, 32'h0000_000F);
      check("rst_irq", {31'h0, irq}, 32'h0);
      reset_n = 1'b1;
      repeat (4) tick();
      rd(ADDR_DATA, rd_val);    check("rst_rd_data", rd_val, 32'h0000_0055);
      rd(ADDR_IRQMASK, rd_val); check("rst_rd_mask", rd_val, 32'h0);
      rd(ADDR_EDGE, rd_val);    check("rst_rd_edge", rd_val, 32'h0);
      check("rst_irq2", {31'h0, irq}, 32'h0);

      // DATA / OUTSET / OUTCLR
      wr(ADDR_DATA, 32'h3C);   check("data_wr", {24'h0, out_port}, 32'h3C);
      wr(ADDR_OUTSET, 32'h81); check("outset", {24'h0, out_port}, 32'hBD);
      wr(ADDR_OUTCLR, 32'h0C); check("outclr", {24'h0, out_port}, 32'hB1);
      rd(ADDR_OUTSET, rd_val); check("rd_outset", rd_val, 32'h0);
      rd(ADDR_OUTCLR, rd_val); check("rd_outclr", rd_val, 32'h0);
      rd(3'd6, rd_val);        check("rd_addr6", rd_val, 32'h0);

      // rising edge capture and irq latency
      wr(ADDR_DIR, 32'h00);
      wr(ADDR_IRQMASK, 32'h01);
      repeat (3) tick();
      check("pre_edge_irq", {31'h0, irq}, 32'h0);
      in_port = 8'h51;
      for (int i = 1; i <= IRQ_LAT; i++) begin
         tick();
         check("irq_latency", {31'h0, irq}, (i == IRQ_LAT) ? 32'h1 : 32'h0);
      end
      rd(ADDR_EDGE, rd_val); check("edge_rise", rd_val, 32'h01);
      wr(ADDR_EDGE, 32'h01);
      check("w1c_irq", {31'h0, irq}, 32'h0);
      rd(ADDR_EDGE, rd_val); check("w1c_edge", rd_val, 32'h0);
      in_port = 8'h50;
      repeat (5) tick();
      rd(ADDR_EDGE, rd_val); check("fall_no_cap", rd_val, 32'h0);
      check("fall_irq", {31'h0, irq}, 32'h0);

      // detection coincident with W1C: set wins
      in_port = 8'h51;
      repeat (SAMP_LAT) tick();
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, rd_val); check("coinc_edge", rd_val, 32'h01);
      check("coinc_irq", {31'h0, irq}, 32'h1);
      tick();
      check("coinc_irq_hold", {31'h0, irq}, 32'h1);
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, rd_val); check("lone_w1c_edge", rd_val, 32'h0);
      check("lone_w1c_irq", {31'h0, irq}, 32'h0);

      // mid-operation reset clears pending irq
      in_port = 8'h50;
      repeat (3) tick();
      in_port = 8'h51;
      repeat (IRQ_LAT) tick();
      check("pre_reset_irq", {31'h0, irq}, 32'h1);
      in_port = 8'hFF;
      reset_n = 1'b0;
      tick();
      check("midrst_irq", {31'h0, irq}, 32'h0);
      tick();
      reset_n = 1'b1;

      // pins high through reset release: no spurious edges
      wr(ADDR_IRQMASK, 32'hFF);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("arm_irq", {31'h0, irq}, 32'h0);
      end
      rd(ADDR_EDGE, rd_val); check("arm_edge", rd_val, 32'h0);

      // all outputs: pin toggles are ignored
      wr(ADDR_DIR, 32'hFF);
      wr(ADDR_DATA, 32'h5A);
      for (int i = 0; i < 6; i++) begin
         in_port = (i % 2 == 0) ? 8'h00 : 8'hFF;
         tick();
         rd(ADDR_DATA, rd_val); check("out_dir_data", rd_val, 32'h5A);
      end
      repeat (3) tick();
      rd(ADDR_EDGE, rd_val); check("out_dir_edge", rd_val, 32'h0);
      check("out_dir_irq", {31'h0, irq}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
